// File: rtl/monitor_pkg.sv
// Shared constants for the vector monitor: default sizing and the layout of a logged entry.
// An entry is {ts, out, x[5:0]} with the timestamp in the upper bits.
package monitor_pkg;

  localparam int DEPTH_DEFAULT = 8;
  localparam int TS_W_DEFAULT  = 16;

  localparam int X_W   = 6;
  localparam int X_LSB = 0;
  localparam int X_MSB = X_LSB + X_W - 1;
  localparam int OUT_BIT = X_MSB + 1;
  localparam int TS_LSB  = OUT_BIT + 1;

  localparam int ENTRY_W_DEFAULT = TS_W_DEFAULT + TS_LSB;

  function automatic int entry_width(input int ts_w);
    return ts_w + TS_LSB;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through synchronous FIFO; rd_data always shows the oldest entry.
// A write while full is accepted only when a read frees a slot on the same edge.
module sync_fifo #(
  parameter int WIDTH = 23,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  // Pointers are exactly AW bits wide, so DEPTH being a power of two gives free wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/vector_monitor.sv
// Logs timestamped {out, x} snapshots whenever the observed vector changes while enabled.
// Entries are buffered in a FWFT FIFO; drops on a full FIFO raise a sticky overflow flag.
module vector_monitor
  import monitor_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int TS_W  = TS_W_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [5:0]               x_in,
  input  logic                     out_in,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [TS_W+6:0]          rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     clr_ovf
);

  localparam int EW = entry_width(TS_W);

  logic [TS_W-1:0] ts_q;
  logic [6:0]      last_q;
  logic [6:0]      obs;
  logic            first_q;
  logic            log_edge;
  logic            drop;
  logic            full;
  logic            empty;
  logic [EW-1:0]   wr_data;

  assign obs      = {out_in, x_in};
  assign log_edge = en && (first_q || (obs != last_q));
  // When full, rd_valid is necessarily 1, so rd_ready alone decides whether a slot frees up.
  assign drop     = log_edge && full && !rd_ready;
  assign rd_valid = !empty;

  always_comb begin
    wr_data                      = '0;
    wr_data[EW-1:TS_LSB]         = ts_q;
    wr_data[OUT_BIT]             = out_in;
    wr_data[X_MSB:X_LSB]         = x_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_q    <= '0;
      last_q  <= '0;
      first_q <= 1'b1;
    end else begin
      if (en) begin
        ts_q    <= ts_q + 1'b1;
        first_q <= 1'b0;
      end else begin
        first_q <= 1'b1;
      end
      if (log_edge) last_q <= obs;
    end
  end

  // Set takes priority over clear so a drop is never hidden by a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (log_edge),
    .wr_data (wr_data),
    .rd_en   (rd_ready),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

endmodule

// File: tb/tb_vector_monitor.sv
// Directed-vector bench for vector_monitor with hand-computed expected entries.
module tb_vector_monitor;

  localparam int DEPTH = 8;
  localparam int TS_W  = 16;
  localparam int EW    = TS_W + 7;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [5:0]    x_in = '0;
  logic          out_in = 1'b0;
  logic          rd_ready = 1'b0;
  logic          clr_ovf = 1'b0;
  logic          rd_valid;
  logic [EW-1:0] rd_data;
  logic [CW-1:0] count;
  logic          overflow;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vector_monitor #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .x_in     (x_in),
    .out_in   (out_in),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .count    (count),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [EW-1:0] ent(input int ts, input bit o, input logic [5:0] x);
    return {TS_W'(ts), o, x};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b0;
    x_in = '0;
    out_in = 1'b0;
    rd_ready = 1'b0;
    clr_ovf = 1'b0;
    step();
    rst = 1'b0;
  endtask

  logic [5:0] seq [4];

  initial begin
    seq[0] = 6'b001001;
    seq[1] = 6'b001100;
    seq[2] = 6'b001001;
    seq[3] = 6'b101001;

    // reset state and single entry for a held vector
    do_reset();
    chk("rst_count", count, 0);
    chk("rst_valid", rd_valid, 0);
    chk("rst_ovf", overflow, 0);
    en = 1'b1;
    x_in = 6'b001001;
    step();
    chk("s1_lat_valid", rd_valid, 1);
    chk("s1_lat_count", count, 1);
    repeat (4) step();
    chk("s1_count", count, 1);
    chk("s1_head", rd_data, ent(0, 0, 6'b001001));

    // change sequence at 5-cycle spacing with consumer always ready
    do_reset();
    en = 1'b1;
    rd_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      x_in = seq[k];
      step();
      chk("s2_valid", rd_valid, 1);
      chk("s2_entry", rd_data, ent(5 * k, 0, seq[k]));
      step();
      chk("s2_drained", count, 0);
      repeat (3) step();
    end

    // full FIFO with simultaneous push and pop
    do_reset();
    en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      x_in = 6'(i);
      step();
    end
    chk("s4_full_count", count, 8);
    chk("s4_full_ovf", overflow, 0);
    x_in = 6'd9;
    rd_ready = 1'b1;
    step();
    chk("s4_pp_count", count, 8);
    chk("s4_pp_ovf", overflow, 0);
    for (int i = 0; i < 8; i++) begin
      chk("s4_drain", rd_data, ent(1 + i, 0, 6'(2 + i)));
      step();
    end
    chk("s4_empty_count", count, 0);
    chk("s4_empty_valid", rd_valid, 0);

    // overflow with ten changes, then clear semantics
    do_reset();
    en = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      x_in = 6'(i);
      step();
      chk("s3_count", count, (i <= 8) ? i : 8);
      chk("s3_ovf", overflow, (i <= 8) ? 0 : 1);
    end
    chk("s3_head", rd_data, ent(0, 0, 6'd1));
    clr_ovf = 1'b1;
    x_in = 6'd11;
    step();
    chk("s3_set_wins", overflow, 1);
    step();
    chk("s3_cleared", overflow, 0);
    clr_ovf = 1'b0;
    rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("s3_drain", rd_data, ent(i, 0, 6'(i + 1)));
      step();
    end
    chk("s3_empty", rd_valid, 0);

    // enable toggle re-logs; out bit change logs
    do_reset();
    en = 1'b1;
    x_in = 6'b000111;
    repeat (3) step();
    chk("s5_count1", count, 1);
    en = 1'b0;
    repeat (2) step();
    chk("s5_hold_count", count, 1);
    en = 1'b1;
    step();
    chk("s5_count2", count, 2);
    chk("s5_head0", rd_data, ent(0, 0, 6'b000111));
    rd_ready = 1'b1;
    step();
    chk("s5_head1", rd_data, ent(3, 0, 6'b000111));
    step();
    chk("s5_drained", count, 0);
    rd_ready = 1'b0;
    out_in = 1'b1;
    step();
    chk("s5_out_entry", rd_data, ent(6, 1, 6'b000111));
    chk("s5_out_count", count, 1);

    // async reset mid-stream; empty push+pop is push only
    do_reset();
    en = 1'b1;
    rd_ready = 1'b1;
    x_in = 6'd1;
    step();
    chk("s6_empty_pp", count, 1);
    rd_ready = 1'b0;
    x_in = 6'd2;
    step();
    x_in = 6'd3;
    step();
    chk("s6_pre_count", count, 3);
    #1;
    rst = 1'b1;
    #1;
    chk("s6_async_count", count, 0);
    chk("s6_async_valid", rd_valid, 0);
    #1;
    rst = 1'b0;
    step();
    chk("s6_post_count", count, 1);
    chk("s6_post_entry", rd_data, ent(0, 0, 6'd3));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vector_monitor.md
VECTOR_MONITOR -- requirements
Module: vector_monitor

Interface
REQ-001 Parameter DEPTH, default 8: FIFO entries; power of two, at least 2.
REQ-002 Parameter TS_W, default 16: timestamp width in bits.
REQ-003 clk  input  1: single clock; all state updates on the rising edge.
REQ-004 rst  input  1: asynchronous, active-high reset.
REQ-005 en  input  1: capture enable.
REQ-006 x_in  input  6: observed stimulus vector; bit0=x1 through bit5=x6.
REQ-007 out_in  input  1: observed DUT output.
REQ-008 rd_valid  output  1: FIFO head entry available.
REQ-009 rd_ready  input  1: consumer accepts the head entry.
REQ-010 rd_data  output  TS_W+7: head entry {ts[TS_W-1:0], out, x[5:0]}; out is bit 6, x is bits 5:0.
REQ-011 count  output  clog2(DEPTH)+1: number of stored entries.
REQ-012 overflow  output  1: sticky flag, set when an entry is dropped.
REQ-013 clr_ovf  input  1: synchronous clear of overflow.

Function
REQ-014 ts_q shall be a free-running timestamp counter that increments by 1 on each edge where en=1, wraps from 2^TS_W-1 to 0, and holds its value when en=0.
REQ-015 first_q shall be set by reset and on each edge where en=0, and cleared after the first logging edge with en=1.
REQ-016 An edge shall be a logging edge when en=1 and either first_q=1 or {out_in,x_in} differs from last_q.
REQ-017 On a logging edge, the block shall push {ts_q pre-increment, out_in, x_in} and load last_q with {out_in,x_in}.
REQ-018 A pushed entry shall appear at rd_data with rd_valid=1 immediately after the logging edge (1-cycle latency).
REQ-019 The FIFO shall be first-word fall-through: rd_valid=(count!=0), and rd_data shall always show the oldest entry.
REQ-020 A pop shall occur on an edge where rd_valid=1 and rd_ready=1; rd_ready with an empty FIFO shall have no effect.
REQ-021 A push when full without a pop in the same edge shall drop the entry, leave count unchanged, set overflow, and still update last_q.
REQ-022 A simultaneous push and pop when full shall accept the push and keep count=DEPTH.
REQ-023 A simultaneous push and pop when empty shall perform the push only; the pop is ignored because rd_valid=0.
REQ-024 When clr_ovf=1 and a drop occur on the same edge, overflow shall end the edge at 1 (set wins).
REQ-025 Read and write pointers shall wrap modulo DEPTH.

Reset
REQ-026 Asserting rst shall immediately force: count=0, rd_valid=0, overflow=0, ts_q=0, last_q=0, first_q=1, and both pointers to 0.
REQ-027 rd_data content during reset is don't-care; the bench shall not check it while rd_valid=0.
REQ-028 Reset asserted mid-operation shall discard all stored entries; the first enabled edge after rst deasserts shall log unconditionally with ts=0.

Structure
REQ-029 Package monitor_pkg shall hold the default DEPTH and TS_W, the entry-width constant (TS_W+7), and the bit-field positions of out and x.
REQ-030 Storage shall be one sub-module, sync_fifo (parameters WIDTH and DEPTH; FWFT; full/empty/count outputs).
REQ-031 Change detection, the timestamp counter, and overflow logic shall live in vector_monitor.

Verification
REQ-032 Scenario: reset, then en=1 with x_in=6'b001001, out_in=0 held for 5 cycles -> exactly one entry {ts=0, out=0, x=001001}, count=1.
REQ-033 Scenario: apply the sequence x=001001, 001100, 001001, 101001 at 5-cycle spacing, rd_ready=1 -> 4 entries with ts values 0, 5, 10, 15, in order.
REQ-034 Scenario: DEPTH=8, rd_ready=0, 10 distinct changes on consecutive edges -> count=8, overflow=1, entries 9 and 10 dropped, head ts=0.
REQ-035 Scenario: FIFO full, change with rd_ready=1 on the same edge -> count stays 8, overflow stays 0, new entry stored at the tail.
REQ-036 Scenario: toggle en 1->0->1 with x_in unchanged -> a new entry on re-enable (first_q), with ts continuing from its held value.
REQ-037 Scenario: assert rst asynchronously mid-stream with count=3 -> count=0 and rd_valid=0 before the next edge; the next enabled edge logs ts=0.
